// File: rtl/regfile_wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_arb_pkg
// Shared constants and types for the two-port register-file writeback
// arbiter: register address width, register count, default data width,
// the writeback request record and a one-hot address decode helper.
// ----------------------------------------------------------------------------
package regfile_wb_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN_DEF   = 32;

    // Writeback request as seen at the default data width.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] v;
        v = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_arb_hold_slot.sv
// ----------------------------------------------------------------------------
// wb_hold_slot
// One-entry holding register for a writeback port. Accepts a request when
// valid && ready, drops requests that target register 0, and releases the
// entry when the arbiter grants it. A grant and a new accept on the same
// edge refill the slot directly, so each port can sustain one write/cycle.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_valid/i_addr/i_data   incoming request
//   i_grant           arbiter grant for the held entry
//   o_ready           slot can accept this cycle (independent of i_valid)
//   o_hold_v/o_hold_addr/o_hold_data   held entry
// ----------------------------------------------------------------------------
module wb_hold_slot
    import regfile_wb_arb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [REG_ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]       i_data,
    input  logic                  i_grant,
    output logic                  o_ready,
    output logic                  o_hold_v,
    output logic [REG_ADDR_W-1:0] o_hold_addr,
    output logic [XLEN-1:0]       o_hold_data
);

    logic                  r_v;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]       r_data;
    logic                  w_accept;
    logic                  w_load;

    // Held contents are discarded during reset, so the port reads as ready.
    assign o_ready  = !rst_n || !r_v || i_grant;
    assign w_accept = i_valid && o_ready;
    // x0 writes are consumed here and never occupy the slot.
    assign w_load   = w_accept && (i_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v    <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_v    <= 1'b1;
            r_addr <= i_addr;
            r_data <= i_data;
        end else if (i_grant) begin
            r_v    <= 1'b0;
        end
    end

    assign o_hold_v    = r_v;
    assign o_hold_addr = r_addr;
    assign o_hold_data = r_data;

endmodule

// File: rtl/regfile_wb_arb.sv
// ----------------------------------------------------------------------------
// regfile_wb_arb
// Two-port writeback arbiter in front of a single-write-port register file.
// Port 0 (pipeline writeback) normally has priority; port 1 (multicycle /
// load writeback) wins once it has waited STARVE_MAX cycles. Also exports a
// per-register busy vector covering every accepted, not yet written value.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   p0_valid/p0_ready/p0_addr/p0_data   port 0 request handshake
//   p1_valid/p1_ready/p1_addr/p1_data   port 1 request handshake
//   we3, a3, wd3                   register file write port
//   busy                           bit r set while a write to r is held
//   starve_flip                    port 1 granted over a pending port 0
// ----------------------------------------------------------------------------
module regfile_wb_arb
    import regfile_wb_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int XLEN       = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic [REG_ADDR_W-1:0] p0_addr,
    input  logic [XLEN-1:0]       p0_data,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic [REG_ADDR_W-1:0] p1_addr,
    input  logic [XLEN-1:0]       p1_data,
    output logic                  we3,
    output logic [REG_ADDR_W-1:0] a3,
    output logic [XLEN-1:0]       wd3,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  starve_flip
);

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    logic                  w_h0_v;
    logic [REG_ADDR_W-1:0] w_h0_addr;
    logic [XLEN-1:0]       w_h0_data;
    logic                  w_h1_v;
    logic [REG_ADDR_W-1:0] w_h1_addr;
    logic [XLEN-1:0]       w_h1_data;
    logic                  w_grant0;
    logic                  w_grant1;
    logic [3:0]            r_starve_q;

    wb_hold_slot #(.XLEN(XLEN)) u_slot0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (p0_valid),
        .i_addr      (p0_addr),
        .i_data      (p0_data),
        .i_grant     (w_grant0),
        .o_ready     (p0_ready),
        .o_hold_v    (w_h0_v),
        .o_hold_addr (w_h0_addr),
        .o_hold_data (w_h0_data)
    );

    wb_hold_slot #(.XLEN(XLEN)) u_slot1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (p1_valid),
        .i_addr      (p1_addr),
        .i_data      (p1_data),
        .i_grant     (w_grant1),
        .o_ready     (p1_ready),
        .o_hold_v    (w_h1_v),
        .o_hold_addr (w_h1_addr),
        .o_hold_data (w_h1_data)
    );

    // Grants are qualified with rst_n so a write held when reset arrives
    // never reaches the register file on the reset edge.
    assign w_grant0 = rst_n && w_h0_v && (!w_h1_v || (r_starve_q < STARVE_MAX_C));
    assign w_grant1 = rst_n && w_h1_v && !w_grant0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_q <= '0;
        end else if (!w_h1_v || w_grant1) begin
            r_starve_q <= '0;
        end else if (r_starve_q < STARVE_MAX_C) begin
            r_starve_q <= r_starve_q + 4'd1;
        end
    end

    always_comb begin
        we3 = 1'b0;
        a3  = '0;
        wd3 = '0;
        if (w_grant0) begin
            we3 = 1'b1;
            a3  = w_h0_addr;
            wd3 = w_h0_data;
        end else if (w_grant1) begin
            we3 = 1'b1;
            a3  = w_h1_addr;
            wd3 = w_h1_data;
        end
    end

    assign starve_flip = w_grant1 && w_h0_v;

    always_comb begin
        busy = '0;
        if (rst_n) begin
            if (w_h0_v) busy = busy | addr_onehot(w_h0_addr);
            if (w_h1_v) busy = busy | addr_onehot(w_h1_addr);
        end
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
module tb_regfile_wb_arb;

    logic        clk;
    logic        rst_n;
    logic        p0_valid, p1_valid;
    logic        p0_ready, p1_ready;
    logic [4:0]  p0_addr, p1_addr;
    logic [31:0] p0_data, p1_data;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy;
    logic        starve_flip;

    int n_tests;
    int n_fail;

    regfile_wb_arb #(.STARVE_MAX(4), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0_valid    (p0_valid),
        .p0_ready    (p0_ready),
        .p0_addr     (p0_addr),
        .p0_data     (p0_data),
        .p1_valid    (p1_valid),
        .p1_ready    (p1_ready),
        .p1_addr     (p1_addr),
        .p1_data     (p1_data),
        .we3         (we3),
        .a3          (a3),
        .wd3         (wd3),
        .busy        (busy),
        .starve_flip (starve_flip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file fed by the write port.
    logic [31:0] rf [32];
    logic        rf_clr;
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (we3) begin
            rf[a3] <= wd3;
        end
    end

    typedef struct {
        logic        rst_n;
        logic        p0v;
        logic [4:0]  p0a;
        logic [31:0] p0d;
        logic        p1v;
        logic [4:0]  p1a;
        logic [31:0] p1d;
        logic        we3;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        p0r;
        logic        p1r;
        logic [31:0] busy;
        logic        flip;
    } vec_t;

    vec_t tv [13];

    function automatic vec_t mk(
        input logic r, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic er0, input logic er1, input logic [31:0] eb, input logic ef);
        vec_t v;
        v.rst_n = r;  v.p0v = v0; v.p0a = a0; v.p0d = d0;
        v.p1v = v1;   v.p1a = a1; v.p1d = d1;
        v.we3 = ew;   v.a3 = ea;  v.wd3 = ed;
        v.p0r = er0;  v.p1r = er1; v.busy = eb; v.flip = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        p0_valid = 1'b0; p0_addr = 5'd0; p0_data = 32'h0;
        p1_valid = 1'b0; p1_addr = 5'd0; p1_data = 32'h0;
    endtask

    // Port-1 starvation sequence captures.
    bit          seen7;
    int          idx7;
    logic        flip7, p0r7;
    logic [31:0] wd7, busy7;
    logic        we_k5;
    logic [4:0]  a_k5;
    logic [31:0] wd_k5;
    int          flips;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rf_clr  = 1'b1;
        rst_n   = 1'b0;
        idle_inputs();

        // rows: rst, p0{v,a,d}, p1{v,a,d} -> we3, a3, wd3, p0r, p1r, busy, flip
        tv[0]  = mk(0, 0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 5'd0,  32'h0,          1, 1, 32'h0,                 0);
        tv[1]  = mk(1, 1, 5'd10, 32'h12345678,   0, 5'd0, 32'h0,          1, 5'd10, 32'h12345678,   1, 1, 32'h1 << 10,           0);
        tv[2]  = mk(1, 0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 5'd0,  32'h0,          1, 1, 32'h0,                 0);
        tv[3]  = mk(1, 1, 5'd5,  32'hAAAA_0001,  1, 5'd6, 32'hBBBB_0002,  1, 5'd5,  32'hAAAA_0001,  1, 0, (32'h1 << 5) | (32'h1 << 6), 0);
        tv[4]  = mk(1, 0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          1, 5'd6,  32'hBBBB_0002,  1, 1, 32'h1 << 6,            0);
        tv[5]  = mk(1, 0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 5'd0,  32'h0,          1, 1, 32'h0,                 0);
        tv[6]  = mk(1, 0, 5'd0,  32'h0,          1, 5'd0, 32'hDEADBEEF,   0, 5'd0,  32'h0,          1, 1, 32'h0,                 0);
        tv[7]  = mk(1, 0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 5'd0,  32'h0,          1, 1, 32'h0,                 0);
        tv[8]  = mk(1, 1, 5'd9,  32'h1,          1, 5'd9, 32'h2,          1, 5'd9,  32'h1,          1, 0, 32'h1 << 9,            0);
        tv[9]  = mk(1, 0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          1, 5'd9,  32'h2,          1, 1, 32'h1 << 9,            0);
        tv[10] = mk(1, 0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 5'd0,  32'h0,          1, 1, 32'h0,                 0);
        tv[11] = mk(1, 1, 5'd3,  32'h0000_0033,  0, 5'd0, 32'h0,          1, 5'd3,  32'h0000_0033,  1, 1, 32'h1 << 3,            0);
        tv[12] = mk(0, 0, 5'd0,  32'h0,          0, 5'd0, 32'h0,          0, 5'd0,  32'h0,          1, 1, 32'h0,                 0);

        repeat (2) @(posedge clk);
        #1;
        rf_clr = 1'b0;
        check("reset_we3",   {31'h0, we3}, 32'h0);
        check("reset_busy",  busy, 32'h0);
        check("reset_ready", {30'h0, p0_ready, p1_ready}, 32'h3);

        for (int i = 0; i < 13; i++) begin
            rst_n    = tv[i].rst_n;
            p0_valid = tv[i].p0v; p0_addr = tv[i].p0a; p0_data = tv[i].p0d;
            p1_valid = tv[i].p1v; p1_addr = tv[i].p1a; p1_data = tv[i].p1d;
            @(posedge clk);
            #1;
            n_tests++;
            if (we3 !== tv[i].we3 || a3 !== tv[i].a3 || wd3 !== tv[i].wd3 ||
                p0_ready !== tv[i].p0r || p1_ready !== tv[i].p1r ||
                busy !== tv[i].busy || starve_flip !== tv[i].flip) begin
                n_fail++;
                $display("FAIL vec%0d: got we3=%0b a3=%0d wd3=%08h p0r=%0b p1r=%0b busy=%08h flip=%0b expected we3=%0b a3=%0d wd3=%08h p0r=%0b p1r=%0b busy=%08h flip=%0b",
                         i, we3, a3, wd3, p0_ready, p1_ready, busy, starve_flip,
                         tv[i].we3, tv[i].a3, tv[i].wd3, tv[i].p0r, tv[i].p1r, tv[i].busy, tv[i].flip);
            end
        end

        check("rf_x10", rf[10], 32'h12345678);
        check("rf_x5",  rf[5],  32'hAAAA_0001);
        check("rf_x6",  rf[6],  32'hBBBB_0002);
        check("rf_x9",  rf[9],  32'h0000_0002);
        check("rf_x0",  rf[0],  32'h0);
        check("rf_x3_reset_discard", rf[3], 32'h0);

        // Sustained port-0 traffic against a single port-1 request.
        rst_n = 1'b1;
        seen7 = 0; idx7 = -1; flips = 0;
        flip7 = 0; p0r7 = 1; wd7 = 0; busy7 = 0;
        we_k5 = 0; a_k5 = 0; wd_k5 = 0;
        for (int k = 0; k < 14; k++) begin
            p0_valid = (k < 10);
            p0_addr  = 5'd11;
            p0_data  = 32'(k);
            p1_valid = (k == 0);
            p1_addr  = 5'd7;
            p1_data  = 32'h77;
            @(posedge clk);
            #1;
            if (starve_flip) flips++;
            if (!seen7 && we3 && a3 == 5'd7) begin
                seen7 = 1; idx7 = k;
                flip7 = starve_flip; p0r7 = p0_ready; wd7 = wd3; busy7 = busy;
            end
            if (k == 5) begin
                we_k5 = we3; a_k5 = a3; wd_k5 = wd3;
            end
        end
        idle_inputs();
        @(posedge clk);
        #1;

        check("starve_x7_written",   {31'h0, seen7}, 32'h1);
        check("starve_write_cycle",  32'(idx7), 32'd4);
        check("starve_flip_at_x7",   {31'h0, flip7}, 32'h1);
        check("starve_p0_ready_x7",  {31'h0, p0r7}, 32'h0);
        check("starve_wd3_x7",       wd7, 32'h77);
        check("starve_busy_x7",      busy7, (32'h1 << 7) | (32'h1 << 11));
        check("starve_flip_count",   32'(flips), 32'd1);
        check("starve_p0_resume",    {26'h0, we_k5, a_k5}, {26'h0, 1'b1, 5'd11});
        check("starve_p0_held_data", wd_k5, 32'd4);
        check("starve_rf_x7",        rf[7], 32'h77);
        check("drain_idle",          {31'h0, we3} | busy, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
